// File: rtl/mux41_pkg.sv
// rtl/mux41_pkg.sv - shared constants and types for the 4:1 round-robin mux
package mux41_pkg;

  localparam int NUM_CH    = 4;
  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] MODE_A = 2'd0;
  localparam logic [1:0] MODE_B = 2'd1;
  localparam logic [1:0] MODE_C = 2'd2;
  localparam logic [1:0] MODE_D = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - 4-way round-robin arbiter, search starts after last grant
module rr_arbiter4
  import mux41_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  input  logic       en,
  output logic [3:0] gnt_onehot,
  output logic [1:0] gnt_idx,
  output logic       any
);

  logic [1:0] cand;

  // Offsets 1..NUM_CH wrap modulo 4, so the last granted channel is checked last.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = last + 2'(k);
      if (en && !any && req[cand]) begin
        any              = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux41_rr.sv
// rtl/mux41_rr.sv - 4:1 round-robin stream mux with a single output register
module mux41_rr
  import mux41_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data_a,
  input  logic [WIDTH-1:0] in_data_b,
  input  logic [WIDTH-1:0] in_data_c,
  input  logic [WIDTH-1:0] in_data_d,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  input  logic             out_ready
);

  state_e           state_q;
  logic [1:0]       last_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       mode_q;

  logic             load_en;
  logic [3:0]       gnt_onehot;
  logic [1:0]       gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] data_d;

  // Holding reset keeps in_ready low even though the FSM already reads EMPTY.
  assign load_en = ((state_q == ST_EMPTY) || out_ready) && !rst;

  rr_arbiter4 u_arb (
    .req        (in_valid),
    .last       (last_q),
    .en         (load_en),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  always_comb begin
    data_d = '0;
    case (gnt_idx)
      MODE_A:  data_d = in_data_a;
      MODE_B:  data_d = in_data_b;
      MODE_C:  data_d = in_data_c;
      MODE_D:  data_d = in_data_d;
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      last_q  <= MODE_D;
      data_q  <= '0;
      mode_q  <= MODE_A;
    end else if (gnt_any) begin
      state_q <= ST_FULL;
      last_q  <= gnt_idx;
      data_q  <= data_d;
      mode_q  <= gnt_idx;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_q <= ST_EMPTY;
    end
  end

  assign in_ready  = gnt_onehot;
  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_mode  = mode_q;

endmodule

// File: tb/tb_mux41_rr.sv
// tb/tb_mux41_rr.sv - scoreboard bench for mux41_rr with directed vectors
module tb_mux41_rr;

  logic       clk;
  logic       rst;
  logic [3:0] in_valid;
  logic [7:0] in_data_a, in_data_b, in_data_c, in_data_d;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_mode;
  logic       out_ready;

  int n_cmp;
  int n_err;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] mode;
  } exp_t;

  exp_t exp_q[$];

  mux41_rr #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data_a (in_data_a),
    .in_data_b (in_data_b),
    .in_data_c (in_data_c),
    .in_data_d (in_data_d),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] m);
    exp_t e;
    e.data = d;
    e.mode = m;
    exp_q.push_back(e);
  endtask

  // Monitor: every output transfer pops one expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {22'd0, out_mode, out_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_data", {24'd0, out_data}, {24'd0, e.data});
        chk("sb_mode", {30'd0, out_mode}, {30'd0, e.mode});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 4'hF;
    in_data_a = 8'h11; in_data_b = 8'h22; in_data_c = 8'h33; in_data_d = 8'h44;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_mode", {30'd0, out_mode}, 32'd0);
    chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
    in_valid = 4'h0;
    rst = 1'b0;
    step();

    // Single word from b
    in_valid = 4'b0010; in_data_b = 8'h5A; out_ready = 1'b1;
    #1 chk("t1_in_ready", {28'd0, in_ready}, 32'b0010);
    push(8'h5A, 2'd1);
    step();
    in_valid = 4'h0;
    #1;
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_data", {24'd0, out_data}, 32'h5A);
    chk("t1_out_mode", {30'd0, out_mode}, 32'd1);
    chk("t1_in_ready_idle", {28'd0, in_ready}, 32'd0);
    step();
    chk("t1_drained", {31'd0, out_valid}, 32'd0);

    // Reset so last_grant=3, then all four channels streaming
    rst = 1'b1; step(); rst = 1'b0; step();
    in_data_a = 8'h11; in_data_b = 8'h22; in_data_c = 8'h33; in_data_d = 8'h44;
    in_valid = 4'b1111;
    begin
      logic [1:0] modes[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [7:0] datas[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      for (int i = 0; i < 5; i++) begin
        #1 chk("t2_in_ready", {28'd0, in_ready}, 32'd1 << modes[i]);
        push(datas[i], modes[i]);
        step();
        chk("t2_no_bubble", {31'd0, out_valid}, 32'd1);
        chk("t2_mode", {30'd0, out_mode}, {30'd0, modes[i]});
      end
    end
    in_valid = 4'h0;
    step();
    chk("t2_drained", {31'd0, out_valid}, 32'd0);

    // Stall: C3 from d held while a waits (last_grant=0, d is the only requester)
    in_valid = 4'b1000; in_data_d = 8'hC3; out_ready = 1'b0;
    #1 chk("t3_load_d", {28'd0, in_ready}, 32'b1000);
    push(8'hC3, 2'd3);
    step();
    in_valid = 4'b0001; in_data_a = 8'hA7;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_ready", {28'd0, in_ready}, 32'd0);
      chk("t3_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_stall_data", {24'd0, out_data}, 32'hC3);
      chk("t3_stall_mode", {30'd0, out_mode}, 32'd3);
      step();
    end
    out_ready = 1'b1;
    #1 chk("t3_release_ready", {28'd0, in_ready}, 32'b0001);
    push(8'hA7, 2'd0);
    step();
    chk("t3_next_data", {24'd0, out_data}, 32'hA7);
    chk("t3_next_mode", {30'd0, out_mode}, 32'd0);
    in_valid = 4'h0;
    step();

    // Set last_grant=2 via channel c, then a/c contend with wrap
    in_valid = 4'b0100; in_data_c = 8'h3C;
    #1 chk("t4_load_c", {28'd0, in_ready}, 32'b0100);
    push(8'h3C, 2'd2);
    step();
    in_valid = 4'b0101; in_data_a = 8'h5E; in_data_c = 8'h6F;
    #1 chk("t4_wrap_a", {28'd0, in_ready}, 32'b0001);
    push(8'h5E, 2'd0);
    step();
    #1 chk("t4_then_c", {28'd0, in_ready}, 32'b0100);
    push(8'h6F, 2'd2);
    step();
    in_valid = 4'h0;
    step();
    step();

    // Reset while holding a word: word is discarded, a wins afterwards
    out_ready = 1'b0; in_valid = 4'b1111;
    in_data_a = 8'h11; in_data_b = 8'h22; in_data_c = 8'h33; in_data_d = 8'h44;
    step();
    chk("t5_held", {31'd0, out_valid}, 32'd1);
    chk("t5_held_mode", {30'd0, out_mode}, 32'd3);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_data", {24'd0, out_data}, 32'd0);
    chk("t5_rst_ready", {28'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("t5_first_a", {28'd0, in_ready}, 32'b0001);
    push(8'h11, 2'd0);
    step();
    chk("t5_mode_a", {30'd0, out_mode}, 32'd0);
    in_valid = 4'h0;
    step();
    step();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
